hwpe_periph_cfg_master: RTL

- Initiator for the HWPE peripheral slave port: accepts single register-access commands on a valid/ready stream and issues them as req/gnt transactions.
- Waits for the tagged r_valid response and returns the read data on a valid/ready response stream.
- Used by cluster-side sequencers and testbenches to program and poll accelerator register files such as the FIR MDC top.
- One outstanding transaction at a time.

---
 rtl/hwpe_periph_cfg_master_pkg.sv | 15 +
 rtl/hwpe_periph_cfg_master_if.sv | 18 +
 rtl/hwpe_periph_cfg_master.sv | 117 +++++++++++
 3 files changed

// File: rtl/hwpe_periph_cfg_master_pkg.sv
// hwpe_periph_cfg_master_pkg: shared types and constants for the peripheral config master
package hwpe_periph_cfg_package;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RSP} periph_cfg_state_e;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } periph_cfg_cmd_t;

    localparam logic [31:0] PERIPH_CFG_ERR_DATA = 32'hBADC_0FFE;

endpackage

// File: rtl/hwpe_periph_cfg_master_if.sv
// hwpe_periph_cfg_master_if: HWPE peripheral req/gnt bus with tagged response
interface hwpe_periph_cfg_master_if #(
    parameter int ID = 10
) ();
    logic          req;
    logic          gnt;
    logic [31:0]   add;
    logic          wen;
    logic [3:0]    be;
    logic [31:0]   data;
    logic [ID-1:0] id;
    logic [31:0]   r_data;
    logic          r_valid;
    logic [ID-1:0] r_id;

    modport master (output req, add, wen, be, data, id, input gnt, r_data, r_valid, r_id);
    modport slave  (input req, add, wen, be, data, id, output gnt, r_data, r_valid, r_id);
endinterface

// File: rtl/hwpe_periph_cfg_master.sv
// hwpe_periph_cfg_master: single-outstanding register access initiator; HWPE_PERIPH_CFG_TIMEOUT_EN adds a WAIT timeout
module hwpe_periph_cfg_master
    import hwpe_periph_cfg_package::*;
#(
    parameter int ID             = 10,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_add_i,
    input  logic        cmd_wen_i,
    input  logic [3:0]  cmd_be_i,
    input  logic [31:0] cmd_data_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_data_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    hwpe_periph_cfg_master_if.master periph
);

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    periph_cfg_state_e state;
    periph_cfg_cmd_t   cmd_q;
    logic [ID-1:0]     tag;

    assign periph.add  = cmd_q.add;
    assign periph.wen  = cmd_q.wen;
    assign periph.be   = cmd_q.be;
    assign periph.data = cmd_q.data;
    assign periph.id   = tag;

`ifdef HWPE_PERIPH_CFG_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    logic          err_q;
    assign rsp_err_o = err_q;
`else
    assign rsp_err_o = 1'b0;
`endif

    // FSM with registered handshake outputs; clear aborts to IDLE but keeps the tag
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= IDLE;
            tag         <= '0;
            cmd_q       <= '0;
            rsp_data_o  <= '0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            periph.req  <= 1'b0;
            rsp_valid_o <= 1'b0;
`ifdef HWPE_PERIPH_CFG_TIMEOUT_EN
            cnt         <= '0;
            err_q       <= 1'b0;
`endif
        end else if (clear_i) begin
            state       <= IDLE;
            cmd_q       <= '0;
            rsp_data_o  <= '0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            periph.req  <= 1'b0;
            rsp_valid_o <= 1'b0;
`ifdef HWPE_PERIPH_CFG_TIMEOUT_EN
            err_q       <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: if (cmd_valid_i) begin
                    cmd_q       <= '{add: cmd_add_i, wen: cmd_wen_i, be: cmd_be_i, data: cmd_data_i};
                    tag         <= tag + 1'b1;
                    state       <= REQ;
                    cmd_ready_o <= 1'b0;
                    busy_o      <= 1'b1;
                    periph.req  <= 1'b1;
                end
                REQ: if (periph.gnt) begin
                    state      <= WAIT;
                    periph.req <= 1'b0;
`ifdef HWPE_PERIPH_CFG_TIMEOUT_EN
                    cnt        <= '0;
`endif
                end
                WAIT: if (periph.r_valid && periph.r_id == tag) begin
                    rsp_data_o  <= cmd_q.wen ? periph.r_data : '0;
                    rsp_valid_o <= 1'b1;
                    state       <= RSP;
`ifdef HWPE_PERIPH_CFG_TIMEOUT_EN
                    err_q       <= 1'b0;
                end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_o  <= PERIPH_CFG_ERR_DATA;
                    err_q       <= 1'b1;
                    rsp_valid_o <= 1'b1;
                    state       <= RSP;
                end else begin
                    cnt <= cnt + 1'b1;
`endif
                end
                RSP: if (rsp_ready_i) begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                    cmd_ready_o <= 1'b1;
                    busy_o      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
